// File: rtl/stream_burst_scheduler.sv
// Drains the stream FIFO downstream in fixed-length, tlast-framed bursts with an idle gap between them.
// Optional perf counters are built when STREAM_SCHED_PERF_EN is defined.
module stream_burst_scheduler #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LEN_W         = 8,
  parameter int unsigned GAP_W         = 8,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LEN_W-1:0]      cfg_burst_len,
  input  logic [GAP_W-1:0]      cfg_gap,
  input  logic [DATA_WIDTH-1:0] fifo_tdata,
  input  logic                  fifo_tvalid,
  output logic                  fifo_tready,
  input  logic                  fifo_almost_full,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic                  busy,
  output logic [CNT_W-1:0]      burst_count,
  output logic                  err_timeout,
  output logic [31:0]           perf_beats,
  output logic [31:0]           perf_stall
);

  localparam int unsigned BLEN_W  = LEN_W + 1;
  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t             state;
  logic [BLEN_W-1:0]  len;
  logic [BLEN_W-1:0]  beat_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic in_burst;
  logic beat;
  logic last_pos;
  logic stall_abort;

  // Zero-latency pass-through while bursting; the FIFO is held off otherwise
  assign in_burst    = (state == BURST);
  assign out_tdata   = in_burst ? fifo_tdata : '0;
  assign out_tvalid  = in_burst & fifo_tvalid;
  assign fifo_tready = in_burst & out_tready;
  assign beat        = out_tvalid & out_tready;
  assign last_pos    = (beat_cnt == (len - BLEN_W'(1)));
  assign out_tlast   = out_tvalid & last_pos;
  assign stall_abort = in_burst & ~fifo_tvalid & (stall_cnt == STALL_W'(STALL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      len         <= '0;
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      gap_cnt     <= '0;
      burst_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && fifo_almost_full) begin
            state     <= BURST;
            busy      <= 1'b1;
            len       <= (cfg_burst_len == '0) ? {1'b1, LEN_W'(0)} : {1'b0, cfg_burst_len};
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        BURST: begin
          if (beat) beat_cnt <= beat_cnt + BLEN_W'(1);
          stall_cnt <= fifo_tvalid ? '0 : stall_cnt + STALL_W'(1);
          // A final beat and an abort are mutually exclusive on tvalid; completion is checked first
          if (beat && last_pos) begin
            state       <= GAP;
            gap_cnt     <= cfg_gap;
            burst_count <= burst_count + CNT_W'(1);
          end else if (stall_abort) begin
            state       <= GAP;
            gap_cnt     <= cfg_gap;
            err_timeout <= 1'b1;
          end
        end
        GAP: begin
          // A gap of 0 or 1 both leave after a single cycle
          if (gap_cnt <= GAP_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAM_SCHED_PERF_EN
  // Saturating accepted-beat and downstream-backpressure counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (beat && (perf_beats != '1)) perf_beats <= perf_beats + 32'd1;
      if (out_tvalid && !out_tready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_beats = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_stream_burst_scheduler.sv
// Randomized bench for stream_burst_scheduler against a burst-level reference model.
module tb_stream_burst_scheduler;
  localparam int unsigned DW    = 32;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned T     = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [LEN_W-1:0] cfg_burst_len;
  logic [GAP_W-1:0] cfg_gap;
  logic [DW-1:0]    fifo_tdata;
  logic             fifo_tvalid;
  logic             fifo_tready;
  logic             fifo_almost_full;
  logic [DW-1:0]    out_tdata;
  logic             out_tvalid;
  logic             out_tready;
  logic             out_tlast;
  logic             busy;
  logic [CNT_W-1:0] burst_count;
  logic             err_timeout;
  logic [31:0]      perf_beats;
  logic [31:0]      perf_stall;

  stream_burst_scheduler #(
    .DATA_WIDTH(DW), .LEN_W(LEN_W), .GAP_W(GAP_W), .STALL_TIMEOUT(T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_burst_len(cfg_burst_len),
    .cfg_gap(cfg_gap), .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid),
    .fifo_tready(fifo_tready), .fifo_almost_full(fifo_almost_full),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .busy(busy), .burst_count(burst_count),
    .err_timeout(err_timeout), .perf_beats(perf_beats), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: FIFO contents plus burst-level totals
  logic [DW-1:0] fifo_q[$];
  int            m_bursts = 0;
  bit            m_err    = 1'b0;
  longint        m_pbeats = 0;
  longint        m_pstall = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fifo_tready"}, fifo_tready, 0);
    check({tag, "_out_tvalid"}, out_tvalid, 0);
    check({tag, "_out_tlast"}, out_tlast, 0);
    check({tag, "_burst_count"}, burst_count, CNT_W'(m_bursts));
    check({tag, "_err_timeout"}, err_timeout, m_err);
`ifdef STREAM_SCHED_PERF_EN
    check({tag, "_perf_beats"}, perf_beats, m_pbeats);
    check({tag, "_perf_stall"}, perf_stall, m_pstall);
`else
    check({tag, "_perf_beats"}, perf_beats, 0);
    check({tag, "_perf_stall"}, perf_stall, 0);
`endif
  endtask

  task automatic push_words(input int n, input bit seq);
    for (int i = 0; i < n; i++) fifo_q.push_back(seq ? DW'(i + 1) : DW'($urandom));
  endtask

  // One burst from the IDLE start cycle through the gap back to IDLE; rst_at >= 0 resets after that many beats
  task automatic run_burst(input int len_cfg, input int gap_cfg, input int rdy_pct,
                           input int vld_pct, input bit drop_en, input int rst_at);
    int  blen;
    int  acc;
    int  stall;
    int  cyc;
    int  glen;
    bit  done;
    bit  aborted;
    blen    = (len_cfg == 0) ? (1 << LEN_W) : len_cfg;
    glen    = (gap_cfg == 0) ? 1 : gap_cfg;
    acc     = 0;
    stall   = 0;
    cyc     = 0;
    done    = 1'b0;
    aborted = 1'b0;

    cfg_burst_len    = LEN_W'(len_cfg);
    cfg_gap          = GAP_W'(gap_cfg);
    enable           = 1'b1;
    fifo_almost_full = 1'b1;
    out_tready       = 1'b1;
    fifo_tvalid      = (fifo_q.size() > 0);
    fifo_tdata       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    #2;
    idle_checks("start");
    step();
    cfg_burst_len = LEN_W'($urandom);

    while (!done && cyc < 2000) begin
      fifo_almost_full = 1'($urandom_range(0, 1));
      out_tready  = ($urandom_range(0, 99) < rdy_pct);
      fifo_tvalid = (fifo_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
      fifo_tdata  = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom);
      if (drop_en && acc >= 2) enable = 1'b0;
      if (rst_at >= 0 && acc == rst_at) begin
        reset = 1'b1;
        step();
        reset            = 1'b0;
        enable           = 1'b0;
        fifo_almost_full = 1'b0;
        fifo_tvalid      = 1'b1;
        out_tready       = 1'b1;
        m_bursts = 0;
        m_err    = 1'b0;
        m_pbeats = 0;
        m_pstall = 0;
        fifo_q.delete();
        #2;
        idle_checks("after_reset");
        check("after_reset_out_tdata", out_tdata, 0);
        return;
      end
      #2;
      check("burst_busy", busy, 1);
      check("burst_out_tvalid", out_tvalid, fifo_tvalid);
      check("burst_fifo_tready", fifo_tready, out_tready);
      if (fifo_tvalid) check("burst_out_tdata", out_tdata, fifo_tdata);
      check("burst_out_tlast", out_tlast, fifo_tvalid && (acc == blen - 1));
      if (fifo_tvalid && !out_tready) m_pstall++;
      if (fifo_tvalid && out_tready) begin
        void'(fifo_q.pop_front());
        acc++;
        m_pbeats++;
        if (acc == blen) done = 1'b1;
      end
      if (fifo_tvalid) begin
        stall = 0;
      end else if (stall == T - 1) begin
        aborted = 1'b1;
        done    = 1'b1;
      end else begin
        stall++;
      end
      step();
      cyc++;
    end
    if (!done) check("burst_cycle_budget", 0, 1);
    if (aborted) m_err = 1'b1;
    else         m_bursts++;

    cfg_gap = GAP_W'($urandom);
    for (int i = 0; i < glen; i++) begin
      out_tready       = 1'($urandom_range(0, 1));
      fifo_tvalid      = 1'($urandom_range(0, 1));
      fifo_almost_full = 1'($urandom_range(0, 1));
      #2;
      check("gap_busy", busy, 1);
      check("gap_fifo_tready", fifo_tready, 0);
      check("gap_out_tvalid", out_tvalid, 0);
      check("gap_out_tlast", out_tlast, 0);
      step();
    end
    fifo_almost_full = 1'b0;
    #2;
    idle_checks("end");
  endtask

  initial begin
    reset            = 1'b1;
    enable           = 1'b0;
    cfg_burst_len    = '0;
    cfg_gap          = '0;
    fifo_tdata       = '0;
    fifo_tvalid      = 1'b0;
    fifo_almost_full = 1'b0;
    out_tready       = 1'b0;
    step();
    step();
    #2;
    idle_checks("reset");
    check("reset_out_tdata", out_tdata, 0);
    reset = 1'b0;
    step();

    // almost_full alone must not start a burst while disabled
    fifo_almost_full = 1'b1;
    repeat (3) begin
      #2;
      check("no_enable_busy", busy, 0);
      step();
    end
    fifo_almost_full = 1'b0;
    enable           = 1'b1;
    repeat (2) begin
      #2;
      check("no_af_busy", busy, 0);
      step();
    end

    // Basic burst, then the next one only after almost_full returns
    push_words(8, 1'b1);
    run_burst(4, 2, 100, 100, 1'b0, -1);
    fifo_tvalid = 1'b1;
    fifo_tdata  = fifo_q[0];
    out_tready  = 1'b1;
    repeat (3) begin
      step();
      #2;
      idle_checks("hold_idle");
    end
    check("basic_leftover", fifo_q.size(), 4);
    run_burst(4, 0, 100, 100, 1'b0, -1);

    push_words(6, 1'b0);
    run_burst(4, 1, 50, 100, 1'b0, -1);
    push_words(6, 1'b0);
    run_burst(4, 3, 100, 100, 1'b1, -1);

    // Stall abort: two beats then the FIFO runs dry
    fifo_q.delete();
    push_words(2, 1'b0);
    run_burst(4, 2, 100, 100, 1'b0, -1);

    push_words(256, 1'b0);
    run_burst(0, 1, 85, 100, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      int l;
      l = $urandom_range(1, 16);
      push_words(l + $urandom_range(0, 4), 1'b0);
      run_burst(l, $urandom_range(0, 5), $urandom_range(50, 100),
                $urandom_range(60, 100), 1'($urandom_range(0, 1)), -1);
    end

    push_words(8, 1'b0);
    run_burst(4, 2, 100, 100, 1'b0, 2);
    push_words(4, 1'b0);
    run_burst(3, 0, 70, 90, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_burst_scheduler.md
Name: stream_burst_scheduler

Overview:
- Sits on the master side of the stream FIFO that buffers the mSGDMA stream source. It owns the FIFO's m_tready.
- Drains the FIFO to a downstream consumer in fixed-length bursts with a programmable idle gap between them.
- A burst starts only when the FIFO reports almost_full. Each burst is framed with tlast on its final beat.
- Stalled bursts are aborted after a timeout; sticky status is reported to software through a PIO.

Parameters:
- DATA_WIDTH, 32, stream data width; matches the FIFO and mSGDMA stream.
- LEN_W, 8, width of cfg_burst_len; a value of 0 encodes 2^LEN_W beats.
- GAP_W, 8, width of cfg_gap.
- STALL_TIMEOUT, 1024, consecutive in-burst cycles with fifo_tvalid=0 before abort; must be ≥1.
- CNT_W, 16, width of burst_count.

Ports:
- clk, in, 1: system 100 MHz clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: allow new bursts to start.
- cfg_burst_len, in, LEN_W: beats per burst; sampled at burst start.
- cfg_gap, in, GAP_W: idle cycles after each burst; sampled at burst end.
- fifo_tdata, in, DATA_WIDTH: FIFO m_tdata.
- fifo_tvalid, in, 1: FIFO m_tvalid.
- fifo_tready, out, 1: drives FIFO m_tready.
- fifo_almost_full, in, 1: FIFO almost_full.
- out_tdata, out, DATA_WIDTH: downstream data.
- out_tvalid, out, 1: downstream valid.
- out_tready, in, 1: downstream ready.
- out_tlast, out, 1: final beat of a burst.
- busy, out, 1: state is not IDLE.
- burst_count, out, CNT_W: completed bursts; wraps.
- err_timeout, out, 1: sticky; a burst was aborted.
- perf_beats, out, 32: beat counter (optional feature).
- perf_stall, out, 32: stall counter (optional feature).

Behaviour:
- Reset: all registers clear in the cycle reset is sampled high, including mid-burst.
  - State returns to IDLE.
  - fifo_tready, out_tvalid, out_tlast, busy, err_timeout = 0.
  - burst_count = 0; perf counters = 0.
- States: IDLE, BURST, GAP.
- IDLE:
  - fifo_tready = 0; out_tvalid = 0.
  - Enters BURST when enable=1 and fifo_almost_full=1.
  - On entry: latch len = cfg_burst_len (0 means 2^LEN_W); clear beat_cnt and stall_cnt.
- BURST datapath: combinational pass-through, zero latency.
  - out_tdata = fifo_tdata.
  - out_tvalid = fifo_tvalid.
  - fifo_tready = out_tready.
- BURST framing and counters:
  - Beat = fifo_tvalid & out_tready; each beat increments beat_cnt.
  - out_tlast = out_tvalid & (beat_cnt == len-1).
  - stall_cnt increments each cycle with fifo_tvalid=0 and clears on fifo_tvalid=1.
  - Only fifo_tvalid=0 counts as a stall; backpressure (out_tready=0) never counts.
- BURST exits:
  - Completion: the beat with tlast goes to GAP and increments burst_count.
  - Abort: stall_cnt reaching STALL_TIMEOUT-1 while fifo_tvalid=0 goes to GAP and sets err_timeout. No tlast is emitted and burst_count is unchanged.
  - If the abort condition and the final beat fall in the same cycle, the final beat wins: completion, no error.
- GAP:
  - fifo_tready = 0; out_tvalid = 0.
  - Counts cfg_gap cycles (sampled on GAP entry), then goes to IDLE.
  - cfg_gap = 0 gives exactly one GAP cycle.
- enable:
  - Checked only in IDLE.
  - Deasserting enable mid-burst does not truncate the burst; it completes or aborts normally.
- err_timeout is cleared only by reset.
- busy = (state != IDLE), registered.
- fifo_almost_full during BURST/GAP is ignored.
- The next burst needs almost_full re-sampled high in IDLE, so at least one IDLE cycle separates bursts.

Optional Feature:
- Macro: STREAM_SCHED_PERF_EN.
- Defined:
  - perf_beats counts every accepted beat.
  - perf_stall counts BURST cycles with out_tvalid & ~out_tready.
  - Both are 32 bits, saturate at 0xFFFFFFFF and clear on reset.
- Undefined: perf_beats and perf_stall are tied to 0 and no counter logic is generated. Ports remain present.

Test Plan:
- Basic burst:
  - Stimulus: cfg_burst_len=4, cfg_gap=2, enable=1, almost_full pulsed, FIFO holding 8 words 0x1..0x8, out_tready=1.
  - Response: 4 beats 0x1..0x4, out_tlast on 0x4, then 2 GAP cycles with tready=0, burst_count=1; a second burst only after almost_full is reasserted.
- Backpressure:
  - Stimulus: len=4, out_tready toggling 1,0,1,0.
  - Response: data order intact; tlast on the 4th accepted beat only; fifo_tready mirrors out_tready.
- Stall abort:
  - Stimulus: STALL_TIMEOUT=8, len=4, FIFO delivers 2 beats then tvalid=0.
  - Response: 8 stall cycles then GAP, err_timeout=1, burst_count unchanged, no tlast.
- Length wrap:
  - Stimulus: cfg_burst_len=0 with LEN_W=8.
  - Response: 256-beat burst, tlast on beat 256.
- Mid-burst controls:
  - Stimulus: enable dropped at beat 2 of 4.
  - Response: burst completes with tlast and returns to IDLE.
  - Stimulus: separately, reset at beat 2.
  - Response: next cycle all outputs are 0 and state is IDLE.
- Perf counters (STREAM_SCHED_PERF_EN defined):
  - Stimulus: 3 bursts of len=4 with 5 backpressure cycles.
  - Response: perf_beats=12, perf_stall=5; both are 0 when the macro is undefined.
